// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO blocks: address-width derivation,
// Gray/binary conversion and the full-compare target used by the write side.
// Helpers operate on MAXW-bit vectors; callers size-cast to their own width.
package fifo_pkg;

   localparam int unsigned MAXW = 32;

   // Address width for a power-of-two depth
   function automatic int unsigned calc_aw(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Binary to Gray; upper bits above the caller's width must be zero
   function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary over the low w bits (XOR prefix from the MSB down)
   function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g,
                                                input int unsigned     w);
      logic [MAXW-1:0] b;
      logic            acc;
      b   = '0;
      acc = 1'b0;
      for (int unsigned k = 0; k < w; k++) begin
         acc          = acc ^ g[w-1-k];
         b[w-1-k]     = acc;
      end
      return b;
   endfunction

   // Gray pointer one full lap ahead of g: top two bits (aw, aw-1) inverted
   function automatic logic [MAXW-1:0] full_cmp(input logic [MAXW-1:0] g,
                                                input int unsigned     aw);
      return g ^ (MAXW'(3) << (aw - 1));
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix), shared by both FIFO sides.
module fifo_gray2bin #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] i_gray,
   output logic [W-1:0] o_bin
);

   // Each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      o_bin = '0;
      for (int unsigned i = 0; i < W; i++) begin
         o_bin[i] = ^(i_gray >> i);
      end
   end

endmodule

// File: rtl/fifo_wfull.sv
// Write-side pointer, full/almost-full and sticky overflow generator for the
// asynchronous FIFO; runs entirely in the w_clk domain.
// Optional fill-level logic (wlevel, almost_full) is built under FIFO_WLEVEL_EN;
// without it those outputs are tied 0.
module fifo_wfull
   import fifo_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int DEPTH     = 16,
   parameter  int AF_MARGIN = 2,
   localparam int AW        = calc_aw(DEPTH)
) (
   input  logic          w_clk,
   input  logic          rst_n,
   input  logic          wr_rq,
   input  logic          ovf_clr,
   input  logic [AW:0]   wsync_ptr2,
   output logic          wr_en,
   output logic [AW-1:0] waddr,
   output logic [AW:0]   wptr,
   output logic          full,
   output logic          almost_full,
   output logic [AW:0]   wlevel,
   output logic          overflow
);

   localparam int PW = AW + 1;

   logic [AW:0] r_bin;
   logic [AW:0] r_wptr;
   logic        r_full;
   logic        r_ovf;

   logic [AW:0] w_bnext;
   logic [AW:0] w_gnext;
   logic        w_fulln;
   logic        w_unused;

   // WIDTH is carried for a common parameter list only
   assign w_unused = ^{WIDTH[0], AF_MARGIN[0]};

   // rst_n gate keeps the RAM from writing while reset is held
   assign wr_en   = wr_rq & ~r_full & rst_n;
   assign w_bnext = r_bin + PW'(wr_en);
   assign w_gnext = PW'(bin2gray(MAXW'(w_bnext)));
   assign w_fulln = (w_gnext == PW'(full_cmp(MAXW'(wsync_ptr2), AW)));

   // Pointer, full and sticky overflow registers (set wins over clear)
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_wptr <= '0;
         r_full <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_bin  <= w_bnext;
         r_wptr <= w_gnext;
         r_full <= w_fulln;
         if (wr_rq && r_full)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   assign waddr    = r_bin[AW-1:0];
   assign wptr     = r_wptr;
   assign full     = r_full;
   assign overflow = r_ovf;

`ifdef FIFO_WLEVEL_EN
   logic [AW:0] w_rbin;
   logic [AW:0] w_leveln;
   logic        w_afn;
   logic [AW:0] r_level;
   logic        r_af;

   fifo_gray2bin #(.W(PW)) u_g2b (
      .i_gray (wsync_ptr2),
      .o_bin  (w_rbin)
   );

   assign w_leveln = w_bnext - w_rbin;
   assign w_afn    = (w_leveln >= PW'(DEPTH - AF_MARGIN));

   // Pessimistic fill level and almost-full against the stale read pointer
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
         r_af    <= 1'b0;
      end else begin
         r_level <= w_leveln;
         r_af    <= w_afn;
      end
   end

   assign wlevel      = r_level;
   assign almost_full = r_af;
`else
   assign wlevel      = '0;
   assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wfull.sv
// Scoreboard bench for fifo_wfull: the driver pushes expected post-edge state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fifo_wfull;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int AFM   = 2;

   logic          w_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_rq = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [AW:0]   wsync_ptr2 = '0;
   logic          wr_en;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wlevel;
   logic          overflow;

   always #5 w_clk = ~w_clk;

   fifo_wfull #(.WIDTH(8), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
      .w_clk       (w_clk),
      .rst_n       (rst_n),
      .wr_rq       (wr_rq),
      .ovf_clr     (ovf_clr),
      .wsync_ptr2  (wsync_ptr2),
      .wr_en       (wr_en),
      .waddr       (waddr),
      .wptr        (wptr),
      .full        (full),
      .almost_full (almost_full),
      .wlevel      (wlevel),
      .overflow    (overflow)
   );

   typedef struct {
      logic        wr_en;
      logic [AW:0] bin;
      logic        full;
      logic        af;
      logic [AW:0] lvl;
      logic        ovf;
      logic        acc;
      logic        tchk;
      int          ph;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model state and inputs pending for the next edge
   logic [AW:0] m_bin = '0, m_lvl = '0;
   logic        m_full = 1'b0, m_af = 1'b0, m_ovf = 1'b0, last_acc = 1'b0;
   logic        p_rq = 1'b0, p_clr = 1'b0;
   logic [AW:0] p_sync = '0;
   logic [AW:0] s;

   function automatic logic [AW:0] g2b(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [AW:0] b2g(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_edge();
      logic        acc;
      logic [AW:0] nb, lvl;
      acc      = p_rq & ~m_full;
      nb       = m_bin + {{AW{1'b0}}, acc};
      lvl      = nb - g2b(p_sync);
      m_ovf    = (p_rq & m_full) | (m_ovf & ~p_clr);
      m_full   = (lvl == (AW+1)'(DEPTH));
      m_af     = (lvl >= (AW+1)'(DEPTH - AFM));
      m_bin    = nb;
      m_lvl    = lvl;
      last_acc = acc;
   endtask

   task automatic push(input int ph, input logic tchk);
      exp_t e;
      e.wr_en = wr_rq & ~m_full & rst_n;
      e.bin   = m_bin;
      e.full  = m_full;
`ifdef FIFO_WLEVEL_EN
      e.af    = m_af;
      e.lvl   = m_lvl;
`else
      e.af    = 1'b0;
      e.lvl   = '0;
`endif
      e.ovf   = m_ovf;
      e.acc   = last_acc;
      e.tchk  = tchk;
      e.ph    = ph;
      q.push_back(e);
   endtask

   task automatic step(input logic rq, input logic clr, input logic [AW:0] sync, input int ph);
      @(posedge w_clk);
      #1;
      model_edge();
      wr_rq      = rq;
      ovf_clr    = clr;
      wsync_ptr2 = sync;
      p_rq       = rq;
      p_clr      = clr;
      p_sync     = sync;
      push(ph, 1'b1);
   endtask

   task automatic chk(input string name, input int ph, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ph=%0d act=%0h exp=%0h", name, ph, act, exp);
      end
   endtask

   // monitor: compare DUT outputs with the oldest expectation, away from posedge
   logic [AW:0] prev_w = '0;
   always @(negedge w_clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("wr_en",       e.ph, 32'(wr_en),       32'(e.wr_en));
         chk("waddr",       e.ph, 32'(waddr),       32'(e.bin[AW-1:0]));
         chk("wptr",        e.ph, 32'(wptr),        32'(b2g(e.bin)));
         chk("full",        e.ph, 32'(full),        32'(e.full));
         chk("almost_full", e.ph, 32'(almost_full), 32'(e.af));
         chk("wlevel",      e.ph, 32'(wlevel),      32'(e.lvl));
         chk("overflow",    e.ph, 32'(overflow),    32'(e.ovf));
         if (e.tchk)
            chk("wptr_toggle", e.ph, 32'($countones(wptr ^ prev_w)), e.acc ? 32'd1 : 32'd0);
         prev_w = wptr;
      end
   end

   initial begin
      // phase 0: reset held, then released with no requests
      @(posedge w_clk);
      #1;
      push(0, 1'b0);
      @(negedge w_clk);
      #2;
      rst_n = 1'b1;
      step(1'b0, 1'b0, '0, 0);

      // phase 1: 16 back-to-back writes, read pointer at 0
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, 1);

      // phase 2: requests held while full, then overflow clear
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 2);
      step(1'b0, 1'b0, '0, 2);
      step(1'b0, 1'b1, '0, 2);
      step(1'b0, 1'b0, '0, 2);

      // phase 3: reader frees one slot, one more write refills
      step(1'b0, 1'b0, 5'b00001, 3);
      step(1'b1, 1'b0, 5'b00001, 3);
      step(1'b0, 1'b0, 5'b00001, 3);
      step(1'b0, 1'b0, 5'b00001, 3);

      // phase 4: 40 writes with the read pointer trailing, crossing wraps
      s = b2g(m_bin - 5'd3);
      step(1'b0, 1'b0, s, 4);
      step(1'b0, 1'b0, s, 4);
      for (int i = 0; i < 40; i++) begin
         s = b2g(m_bin - 5'd3);
         step(1'b1, 1'b0, s, 4);
      end
      step(1'b0, 1'b0, s, 4);
      step(1'b0, 1'b0, s, 4);

      // phase 5: fill to level 9, then async reset mid-stream
      s = b2g(m_bin);
      step(1'b0, 1'b0, s, 5);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, s, 5);
      step(1'b0, 1'b0, s, 5);
      @(posedge w_clk);
      #1;
      model_edge();
      rst_n      = 1'b0;
      wr_rq      = 1'b1;
      wsync_ptr2 = '0;
      m_bin = '0; m_lvl = '0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; last_acc = 1'b0;
      p_rq = 1'b0; p_clr = 1'b0; p_sync = '0;
      push(5, 1'b0);
      @(negedge w_clk);
      #2;
      rst_n = 1'b1;
      wr_rq = 1'b0;

      // phase 6: first write after reset lands at address 0
      step(1'b1, 1'b0, '0, 6);
      step(1'b0, 1'b0, '0, 6);
      step(1'b0, 1'b0, '0, 6);

      // bounded drain of the scoreboard
      for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge w_clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
